arf_commit_ctrl: RTL
====================

Name: arf_commit_ctrl

Overview:
- Sits between ROB commit and the architectural register file (ARF).
- Buffers retired register writes in a compacted entry FIFO and drains them onto NUM_WP ARF write ports, so the ARF can be built with fewer write ports than commit width.
- Resolves same-cycle WAW, drops x0 writes, and arbitrates a debug write port by quiescing commit traffic first.

Parameters:
- Cfg, config_pkg::EmptyCfg, core configuration; XLEN taken from Cfg.XLEN.
- COMMIT_WIDTH, Cfg.NRET, ROB commit lanes per cycle.
- NUM_WP, 2, ARF write ports driven; must be 1..COMMIT_WIDTH.
- DEPTH, 8, FIFO entries; power of 2, >= COMMIT_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- cmt_valid_i  in  [COMMIT_WIDTH]  per-lane retire write valid.
- cmt_rd_i  in  [COMMIT_WIDTH][5]  destination architectural register.
- cmt_data_i  in  [COMMIT_WIDTH][XLEN]  write data.
- cmt_ready_o  out  1  bundle accept; independent of cmt_valid_i.
- dbg_req_i  in  1  debug register write request; held until granted.
- dbg_addr_i  in  5  debug target register.
- dbg_data_i  in  XLEN  debug write data.
- dbg_gnt_o  out  1  one-cycle pulse when the debug write is driven.
- arf_we_o  out  [NUM_WP]  ARF write enables.
- arf_waddr_o  out  [NUM_WP][5]  ARF write addresses.
- arf_wdata_o  out  [NUM_WP][XLEN]  ARF write data.
- empty_o  out  1  FIFO empty and state RUN.
- count_o  out  clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
Reset:
- Async reset clears pointers and count; state=RUN; FIFO contents are discarded, including on reset mid-drain.
- Reset values: arf_we_o=0, dbg_gnt_o=0, cmt_ready_o=1, empty_o=1, count_o=0.

Enqueue:
- Bundle accepted on a cycle with cmt_ready_o=1; lanes with cmt_valid_i=0 or rd==0 are discarded.
- Remaining lanes are compacted in lane order (lane 0 oldest) and written at tail, tail+1, ...; pointers wrap modulo DEPTH.
- cmt_ready_o = (state==RUN) && (DEPTH - count >= COMMIT_WIDTH), using registered count only.

Drain:
- n_pop = min(count, NUM_WP) on registered count; outputs are combinational from head..head+n_pop-1.
- Slot j carries entry head+j; arf_we_o[j] = (j < n_pop).
- WAW: arf_we_o[j] is cleared if some k with j < k < n_pop has the same address, so the youngest entry wins.
- Head advances by n_pop each cycle in RUN and QUIESCE.
- Same-cycle enqueue and pop: count_next = count + n_enq - n_pop.
- Latency: an entry accepted at edge N appears on arf_* in cycle N+1 at the earliest and is written by the ARF at edge N+1.

FSM:
- RUN: dbg_req_i=1 -> QUIESCE. A bundle presented in the same cycle is still accepted.
- QUIESCE: cmt_ready_o=0; continue draining; when count==0 -> DBG_WR.
- DBG_WR: for one cycle, slot 0 = {dbg_addr_i, dbg_data_i}, arf_we_o[0] = (dbg_addr_i != 0), other slots 0; dbg_gnt_o=1 (also when addr==0); -> RUN.
- All commits accepted before the debug request are therefore written before the debug write.

Optional Feature:
- Macro ARF_CMT_BYPASS_EN, defined:
  - In RUN with count==0, up to NUM_WP compacted accepted entries drive arf_* combinationally in the accept cycle (zero latency); the rest are enqueued.
  - WAW masking applies across the bypassed slots.
  - Adds a cmt_* -> arf_* combinational path.
- Not defined: every entry passes through the FIFO (minimum 1-cycle latency).

Test Plan (COMMIT_WIDTH=4, NUM_WP=2, DEPTH=8, no bypass):
- Reset asserted mid-drain with count=5 -> immediately count_o=0, arf_we_o=0, cmt_ready_o=1, empty_o=1; no further writes.
- Bundle valid=1111, rd=1,2,3,4, data=A,B,C,D at edge N -> cycle N+1: we=11, addr 1,2 (A,B); N+2: addr 3,4 (C,D); N+3: empty_o=1.
- valid=0011, rd0=5 data 0x11, rd1=5 data 0x22 -> next cycle we=10, waddr[1]=5, wdata[1]=0x22.
- valid=1111, rd=0,0,0,7 -> count_o=1; single write to x7; x0 never driven.
- Full 4-entry bundles every cycle from empty -> counts 4 then 6; cmt_ready_o=0 while count>4; all entries drained in order with no loss or duplication.
- dbg_req_i with count=3, addr=9, data=0xDEAD -> cmt_ready_o=0 next cycle; 2 drain cycles; then one cycle we=01, waddr[0]=9, wdata[0]=0xDEAD, dbg_gnt_o=1; RUN next cycle.

Source files
------------

// File: rtl/arf_commit_ctrl.sv
// Architectural register file commit controller.
// Buffers retired register writes in a compacted FIFO and drains them onto
// NUM_WP ARF write ports. Same-cycle WAW is resolved so the youngest write
// wins, x0 writes are dropped, and debug writes are serialized after all
// previously accepted commits.
// Optional build macro: ARF_CMT_BYPASS_EN. It lets an empty FIFO forward up
// to NUM_WP entries straight to the ARF in the accept cycle.

package config_pkg;
    typedef struct packed {
        logic [31:0] XLEN;
        logic [31:0] NRET;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{XLEN: 32'd32, NRET: 32'd4};
endpackage

module arf_commit_ctrl #(
    parameter config_pkg::cfg_t Cfg          = config_pkg::EmptyCfg,
    parameter int unsigned      COMMIT_WIDTH = Cfg.NRET,
    parameter int unsigned      NUM_WP       = 2,
    parameter int unsigned      DEPTH        = 8,
    localparam int unsigned     XLEN         = Cfg.XLEN,
    localparam int unsigned     PW           = $clog2(DEPTH),
    localparam int unsigned     CW           = $clog2(DEPTH + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [COMMIT_WIDTH-1:0]             cmt_valid_i,
    input  logic [COMMIT_WIDTH-1:0][4:0]        cmt_rd_i,
    input  logic [COMMIT_WIDTH-1:0][XLEN-1:0]   cmt_data_i,
    output logic                                cmt_ready_o,
    input  logic                                dbg_req_i,
    input  logic [4:0]                          dbg_addr_i,
    input  logic [XLEN-1:0]                     dbg_data_i,
    output logic                                dbg_gnt_o,
    output logic [NUM_WP-1:0]                   arf_we_o,
    output logic [NUM_WP-1:0][4:0]              arf_waddr_o,
    output logic [NUM_WP-1:0][XLEN-1:0]         arf_wdata_o,
    output logic                                empty_o,
    output logic [CW-1:0]                       count_o
);

    typedef enum logic [1:0] {RUN, QUIESCE, DBG_WR} state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           head_q, tail_q;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           n_pop, n_enq;

    logic [4:0]              mem_addr [DEPTH];
    logic [XLEN-1:0]         mem_data [DEPTH];

    logic [COMMIT_WIDTH-1:0]         enq_we;
    logic [COMMIT_WIDTH-1:0][PW-1:0] enq_ptr;
    logic [NUM_WP-1:0]               byp_we;
    logic [NUM_WP-1:0][4:0]          byp_addr;
    logic [NUM_WP-1:0][XLEN-1:0]     byp_data;
    logic [NUM_WP-1:0]               slot_v;

    // Accept and status flags depend only on registered state and count.
    assign cmt_ready_o = (state_q == RUN) && (count_q <= CW'(DEPTH - COMMIT_WIDTH));
    assign empty_o     = (state_q == RUN) && (count_q == '0);
    assign count_o     = count_q;

    // Pop up to NUM_WP entries per cycle; the debug cycle never pops.
    always_comb begin
        n_pop = '0;
        if (state_q != DBG_WR)
            n_pop = (count_q > CW'(NUM_WP)) ? CW'(NUM_WP) : count_q;
    end

    // Compact accepted lanes in lane order; the oldest ones may bypass the FIFO.
    always_comb begin
        int unsigned kept;
        int unsigned byp_limit;
        int unsigned rank [COMMIT_WIDTH];
        logic [COMMIT_WIDTH-1:0] keep;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        kept      = 0;
        byp_limit = 0;
        keep      = '0;
        n_enq     = '0;
        enq_we    = '0;
        enq_ptr   = '0;
        byp_we    = '0;
        byp_addr  = '0;
        byp_data  = '0;
`ifdef ARF_CMT_BYPASS_EN
        if (state_q == RUN && count_q == '0)
            byp_limit = NUM_WP;
`endif
        for (int l = 0; l < COMMIT_WIDTH; l++) begin
            rank[l] = 0;
            if (cmt_ready_o && cmt_valid_i[l] && cmt_rd_i[l] != 5'd0) begin
                keep[l] = 1'b1;
                rank[l] = kept;
                if (kept >= byp_limit) begin
                    enq_we[l]  = 1'b1;
                    enq_ptr[l] = tail_q + PW'(kept - byp_limit);
                    n_enq      = n_enq + CW'(1);
                end
                kept = kept + 1;
            end
        end
        for (int j = 0; j < NUM_WP; j++) begin
            for (int l = 0; l < COMMIT_WIDTH; l++) begin
                if (keep[l] && rank[l] == j && j < byp_limit) begin
                    byp_we[j]   = 1'b1;
                    byp_addr[j] = cmt_rd_i[l];
                    byp_data[j] = cmt_data_i[l];
                end
            end
        end
    end

    // Drive write ports from the FIFO head (or bypass / debug), then mask WAW losers.
    always_comb begin
        arf_we_o    = '0;
        arf_waddr_o = '0;
        arf_wdata_o = '0;
        dbg_gnt_o   = 1'b0;
        slot_v      = '0;
        if (state_q == DBG_WR) begin
            arf_we_o[0]    = (dbg_addr_i != 5'd0);
            arf_waddr_o[0] = dbg_addr_i;
            arf_wdata_o[0] = dbg_data_i;
            dbg_gnt_o      = 1'b1;
        end else begin
            for (int j = 0; j < NUM_WP; j++) begin
                if (CW'(j) < n_pop) begin
                    slot_v[j]      = 1'b1;
                    arf_waddr_o[j] = mem_addr[head_q + PW'(j)];
                    arf_wdata_o[j] = mem_data[head_q + PW'(j)];
                end else if (byp_we[j]) begin
                    slot_v[j]      = 1'b1;
                    arf_waddr_o[j] = byp_addr[j];
                    arf_wdata_o[j] = byp_data[j];
                end
            end
            for (int j = 0; j < NUM_WP; j++) begin
                arf_we_o[j] = slot_v[j];
                for (int k = j + 1; k < NUM_WP; k++) begin
                    if (slot_v[k] && arf_waddr_o[k] == arf_waddr_o[j])
                        arf_we_o[j] = 1'b0;
                end
            end
        end
    end

    // Next state: quiesce commits on a debug request, write once the FIFO is empty.
    always_comb begin
        state_d = state_q;
        count_d = count_q + n_enq - n_pop;
        unique case (state_q)
            RUN:     if (dbg_req_i) state_d = QUIESCE;
            QUIESCE: if (count_q == '0) state_d = DBG_WR;
            DBG_WR:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Pointer, occupancy and FSM registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_q + PW'(n_pop);
            tail_q  <= tail_q + PW'(n_enq);
            count_q <= count_d;
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is not reset; count and pointers alone define which entries are live.
        for (int l = 0; l < COMMIT_WIDTH; l++) begin
            if (enq_we[l]) begin
                mem_addr[enq_ptr[l]] <= cmt_rd_i[l];
                mem_data[enq_ptr[l]] <= cmt_data_i[l];
            end
        end
    end

endmodule
